// File: rtl/restoring_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : restoring_divider_if
//  Description : Narrow serial operand/result bus shared by the serial
//                arithmetic units (request pulse, operand bus, result bus,
//                done and error flags).
//  Revision    : 1.0  initial release
// ============================================================================
interface restoring_divider_if #(
    parameter int N = 5
);
    logic         start;
    logic [N-1:0] data_in;
    logic [N-1:0] data_out;
    logic         done;
    logic         err;

    // Requester side: issues start and operands, collects results.
    modport master (
        output start,
        output data_in,
        input  data_out,
        input  done,
        input  err
    );

    // Arithmetic-unit side.
    modport slave (
        input  start,
        input  data_in,
        output data_out,
        output done,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : restoring_divider
//  Description : Sequential signed restoring divider. Dividend and divisor
//                arrive serially after a start pulse; magnitudes are divided
//                with one shift/subtract/restore step per cycle, then the
//                sign-corrected quotient and remainder are presented on two
//                consecutive done cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module restoring_divider #(
    parameter int N = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    restoring_divider_if.slave bus
);

    localparam int                 c_CNT_W     = (N > 2) ? $clog2(N) : 1;
    localparam logic [c_CNT_W-1:0] c_ITER_LAST = c_CNT_W'(N - 1);
    localparam logic [N-1:0]       c_MOST_NEG  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_X  = 3'd1,
        S_LD_Y  = 3'd2,
        S_CALC  = 3'd3,
        S_OUT_Q = 3'd4,
        S_OUT_R = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [N-1:0]       r_x;      // dividend as received (signed)
    logic [N-1:0]       r_y;      // divisor as received (signed)
    logic [N-1:0]       r_ya;     // |divisor|, unsigned
    logic [N:0]         r_r;      // partial remainder
    logic [N-1:0]       r_q;      // |dividend| shifting out, quotient shifting in

    logic [N-1:0]       w_abs_in;
    logic [N-1:0]       w_abs_x;
    logic [N+1:0]       w_r_sh;
    logic [N-1:0]       w_q_sh;
    logic [N+1:0]       w_t;
    logic               w_div0;
    logic               w_ovf;
    logic [N-1:0]       w_q_out;
    logic [N-1:0]       w_r_out;

    // Magnitudes; the most negative value maps to 2^(N-1) as unsigned.
    assign w_abs_in = bus.data_in[N-1] ? (~bus.data_in + 1'b1) : bus.data_in;
    assign w_abs_x  = r_x[N-1] ? (~r_x + 1'b1) : r_x;

    // {R,Q} shifted left by one. R carries one extra guard bit so the bit
    // leaving R still takes part in the trial subtraction.
    assign w_r_sh = {r_r, r_q[N-1]};
    assign w_q_sh = {r_q[N-2:0], 1'b0};
    assign w_t    = w_r_sh - {2'b00, r_ya};

    // Special cases and sign-corrected results, all from registered state.
    assign w_div0  = (r_y == '0);
    assign w_ovf   = (r_x == c_MOST_NEG) && (r_y == '1);
    assign w_q_out = w_div0 ? '0 :
                     ((r_x[N-1] ^ r_y[N-1]) ? (~r_q + 1'b1) : r_q);
    assign w_r_out = w_div0 ? r_x :
                     (r_x[N-1] ? (~r_r[N-1:0] + 1'b1) : r_r[N-1:0]);

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Controller next-state logic; a zero divisor skips the iterations.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_LD_X;
            S_LD_X:  w_state_nxt = S_LD_Y;
            S_LD_Y:  w_state_nxt = (bus.data_in == '0) ? S_OUT_Q : S_CALC;
            S_CALC:  if (r_cnt == c_ITER_LAST) w_state_nxt = S_OUT_Q;
            S_OUT_Q: w_state_nxt = S_OUT_R;
            S_OUT_R: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, then one restoring step per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_ya  <= '0;
            r_r   <= '0;
            r_q   <= '0;
        end else begin
            case (r_state)
                S_LD_X: begin
                    r_x <= bus.data_in;
                end
                S_LD_Y: begin
                    r_y   <= bus.data_in;
                    r_ya  <= w_abs_in;
                    r_r   <= '0;
                    r_q   <= w_abs_x;
                    r_cnt <= '0;
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_t[N+1]) begin
                        r_r <= w_t[N:0];
                        r_q <= {w_q_sh[N-1:1], 1'b1};
                    end else begin
                        r_r <= w_r_sh[N:0];
                        r_q <= w_q_sh;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result bus decoded from state: quotient, then remainder, else zero.
    always_comb begin
        bus.data_out = '0;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        case (r_state)
            S_OUT_Q: begin
                bus.data_out = w_q_out;
                bus.done     = 1'b1;
                bus.err      = w_div0 | w_ovf;
            end
            S_OUT_R: begin
                bus.data_out = w_r_out;
                bus.done     = 1'b1;
                bus.err      = w_div0 | w_ovf;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_restoring_divider
//  Description : Self-checking bench for restoring_divider: directed cases,
//                held-start / back-to-back operation, asynchronous reset and
//                an all-pairs sweep in randomized order against an
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_restoring_divider;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    restoring_divider_if #(.N(N)) bus ();

    restoring_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference model: plain signed arithmetic (SV / truncates toward zero,
    // % takes the sign of the dividend) plus the two error cases.
    function automatic void ref_div(input int x, input int y,
                                    output logic [4:0] q, output logic [4:0] r, output logic e);
        int qi;
        int ri;
        if (y == 0) begin
            q = 5'd0;
            r = 5'(x);
            e = 1'b1;
        end else if (x == -16 && y == -1) begin
            q = 5'b10000;
            r = 5'd0;
            e = 1'b1;
        end else begin
            qi = x / y;
            ri = x % y;
            q  = 5'(qi);
            r  = 5'(ri);
            e  = 1'b0;
        end
    endfunction

    // One full operation: start, operands, then both result cycles and the
    // return to idle. Ends #1 after the edge that returns to IDLE.
    task automatic run_op(input int x, input int y, input bit hold);
        logic [4:0] eq;
        logic [4:0] er;
        logic       ee;
        int         lat;
        string      tag;
        ref_div(x, y, eq, er, ee);
        tag = $sformatf("%0d/%0d", x, y);
        bus.start = 1'b1;
        @(posedge clk); #1;                       // E0
        if (!hold) bus.start = 1'b0;
        bus.data_in = 5'(x);
        lat = 0;
        @(posedge clk); #1;                       // E1
        bus.data_in = 5'(y);
        lat = 1;
        @(posedge clk); #1;                       // E2
        bus.data_in = 5'($urandom);
        lat = 2;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            bus.data_in = 5'($urandom);
            lat++;
        end
        check({tag, " latency"}, lat, (y == 0) ? 2 : 7);
        check({tag, " quotient"}, bus.data_out, eq);
        check({tag, " err_q"}, bus.err, ee);
        @(posedge clk); #1;
        check({tag, " done_r"}, bus.done, 1'b1);
        check({tag, " remainder"}, bus.data_out, er);
        check({tag, " err_r"}, bus.err, ee);
        @(posedge clk); #1;
        check({tag, " done_end"}, bus.done, 1'b0);
        check({tag, " out_end"}, bus.data_out, 5'd0);
        bus.start = 1'b0;
    endtask

    int dx[12] = '{13, -13, 13, -13, 7, -16, -16, 0, -16, 15, -1, -16};
    int dy[12] = '{ 4,   4, -4,  -4, 0,  -1,   1, 5, -16, -16, 0,  0};

    initial begin
        bit saw_done;
        int idx;
        int ofs;

        bus.start   = 1'b0;
        bus.data_in = '0;
        rst         = 1'b1;
        #12;
        check("reset done", bus.done, 1'b0);
        check("reset data_out", bus.data_out, 5'd0);
        check("reset err", bus.err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the test plan and boundaries.
        for (int i = 0; i < 12; i++) run_op(dx[i], dy[i], 1'b0);

        // Start held high through operations; back-to-back issue.
        run_op(13, 4, 1'b1);
        run_op(-7, 3, 1'b1);
        run_op(5, -2, 1'b0);

        // Reset during the third iteration aborts with no done pulse.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.data_in = 5'd13;
        @(posedge clk); #1;
        bus.data_in = 5'd4;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midcalc rst done", bus.done, 1'b0);
        check("midcalc rst data_out", bus.data_out, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("no done after abort", saw_done, 1'b0);
        run_op(15, 2, 1'b0);

        // Reset while results are displayed clears outputs without a clock.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.data_in = 5'd9;
        @(posedge clk); #1;
        bus.data_in = 5'd2;
        repeat (6) @(posedge clk);
        #1;
        check("pre-rst done", bus.done, 1'b1);
        check("pre-rst quotient", bus.data_out, 5'd4);
        #2;
        rst = 1'b1;
        #1;
        check("async rst done", bus.done, 1'b0);
        check("async rst data_out", bus.data_out, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Every operand pair, visited in a randomized order.
        ofs = int'($urandom_range(0, 1023));
        for (int i = 0; i < 1024; i++) begin
            idx = (i * 17 + ofs) % 1024;
            run_op((idx >> 5) - 16, (idx & 31) - 16, ($urandom_range(0, 3) == 0));
        end

        // Additional fully random pairs.
        for (int i = 0; i < 100; i++) begin
            run_op(int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
                   ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop if the run never reaches its summary.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
